// File: rtl/attn_tile_if.sv
// Control/handshake bundle for the attention tile controller.
// slave = controller side, master = sequencer/testbench side.
interface attn_tile_if #(
  parameter int N_ROWS  = 4,
  parameter int N_COLS  = 4,
  parameter int K_DEPTH = 8
);
  localparam int RW = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1;
  localparam int CW = (N_COLS  > 1) ? $clog2(N_COLS)  : 1;
  localparam int KW = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;

  logic          start, abort, load_valid, out_ready;
  logic          load_en, compute_en, acc_clr, out_valid, done, busy;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic [KW-1:0] k_idx;
  logic [2:0]    state_out;

  modport slave (
    input  start, abort, load_valid, out_ready,
    output load_en, compute_en, acc_clr, out_valid, done, busy,
           row_idx, col_idx, k_idx, state_out
  );
  modport master (
    output start, abort, load_valid, out_ready,
    input  load_en, compute_en, acc_clr, out_valid, done, busy,
           row_idx, col_idx, k_idx, state_out
  );
endinterface

// File: rtl/attn_tile_ctrl.sv
// Sweeps an N_ROWS x N_COLS output tile grid: per tile LOAD -> K_DEPTH COMPUTE
// cycles -> WRITE handshake, then a one-cycle DONE pulse after the last tile.
module attn_tile_ctrl #(
  parameter int N_ROWS  = 4,
  parameter int N_COLS  = 4,
  parameter int K_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  attn_tile_if.slave bus
);
  localparam int RW = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1;
  localparam int CW = (N_COLS  > 1) ? $clog2(N_COLS)  : 1;
  localparam int KW = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(K_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e        state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [KW-1:0] k_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else if (bus.abort && state_q != S_IDLE) begin
      // abort outranks every other transition and never pulses done
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start && !bus.abort) begin
          state_q <= S_LOAD;
          row_q   <= '0;
          col_q   <= '0;
          k_q     <= '0;
        end
        S_LOAD: if (bus.load_valid) begin
          state_q <= S_COMPUTE;
          k_q     <= '0;
        end
        S_COMPUTE: begin
          if (k_q == K_LAST) begin
            state_q <= S_WRITE;
            k_q     <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_WRITE: if (bus.out_ready) begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
              row_q   <= '0;
              state_q <= S_DONE;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= S_LOAD;
            end
          end else begin
            col_q   <= col_q + 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          row_q   <= '0;
          col_q   <= '0;
          k_q     <= '0;
        end
      endcase
    end
  end

  // Moore decodes of registered state only, so reset clears them immediately
  assign bus.load_en    = (state_q == S_LOAD);
  assign bus.compute_en = (state_q == S_COMPUTE);
  assign bus.acc_clr    = (state_q == S_COMPUTE) && (k_q == '0);
  assign bus.out_valid  = (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.row_idx    = row_q;
  assign bus.col_idx    = col_q;
  assign bus.k_idx      = k_q;
  assign bus.state_out  = state_q;
endmodule

// File: tb/tb_attn_tile_ctrl.sv
// Scoreboarded bench: a 2x2x3 instance for sweep/stall/abort/reset cases
// and a 1x1x1 instance for the degenerate single-tile case.
module tb_attn_tile_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  attn_tile_if #(.N_ROWS(2), .N_COLS(2), .K_DEPTH(3)) ifa ();
  attn_tile_if #(.N_ROWS(1), .N_COLS(1), .K_DEPTH(1)) ifb ();

  attn_tile_ctrl #(.N_ROWS(2), .N_COLS(2), .K_DEPTH(3)) ua (.clk(clk), .rst(rst), .bus(ifa.slave));
  attn_tile_ctrl #(.N_ROWS(1), .N_COLS(1), .K_DEPTH(1)) ub (.clk(clk), .rst(rst), .bus(ifb.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic r; logic c; } rc_t;
  rc_t sb[$];

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 0; ifa.abort = 0; ifa.load_valid = 0; ifa.out_ready = 0;
    ifb.start = 0; ifb.abort = 0; ifb.load_valid = 0; ifb.out_ready = 0;
    #2;
    n_cmp++;
    if ({ifa.load_en, ifa.compute_en, ifa.acc_clr, ifa.out_valid, ifa.done, ifa.busy,
         ifa.row_idx, ifa.col_idx, ifa.k_idx, ifa.state_out} !== '0) begin
      n_bad++; $display("FAIL reset_a: outputs not all zero, state=%0d busy=%b", ifa.state_out, ifa.busy);
    end
    n_cmp++;
    if ({ifb.load_en, ifb.compute_en, ifb.acc_clr, ifb.out_valid, ifb.done, ifb.busy,
         ifb.state_out} !== '0) begin
      n_bad++; $display("FAIL reset_b: outputs not all zero, state=%0d", ifb.state_out);
    end
    @(negedge clk); rst = 1'b0;
    ifa.start = 1; ifa.abort = 1;
    @(negedge clk);
    n_cmp++;
    if (ifa.state_out !== 3'd0 || ifa.busy !== 1'b0) begin
      n_bad++; $display("FAIL start_abort_idle: state=%0d busy=%b exp state=0 busy=0", ifa.state_out, ifa.busy);
    end
    ifa.start = 0; ifa.abort = 0;
    @(negedge clk);
  endtask

  // Runs one full sweep on the 2x2x3 instance with optional first-LOAD and
  // first-WRITE stalls; returns per-phase observations for the caller.
  task automatic run_a(input int lstall, input int wstall, input int exp_done,
                       output int first_comp, output int ld_first, output int ov_first,
                       output int clr_cnt, output bit col_held);
    int  done_cyc, dcnt, tile, lcnt, wcnt;
    rc_t e;
    first_comp = -1; ld_first = 0; ov_first = 0; clr_cnt = 0; col_held = 1;
    done_cyc = -1; dcnt = 0; tile = 0; lcnt = 0; wcnt = 0;
    sb.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) sb.push_back('{r: r[0], c: c[0]});
    @(negedge clk);
    ifa.start = 1; ifa.load_valid = 1; ifa.out_ready = 1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      ifa.start = 0;
      if (ifa.load_en && tile == 0 && lcnt < lstall) begin ifa.load_valid = 0; lcnt++; end
      else ifa.load_valid = 1;
      if (ifa.out_valid && tile == 0 && wcnt < wstall) begin ifa.out_ready = 0; wcnt++; end
      else ifa.out_ready = 1;
      n_cmp++;
      if (ifa.acc_clr !== (ifa.compute_en && ifa.k_idx == 2'd0)) begin
        n_bad++; $display("FAIL acc_clr_decode: cyc=%0d acc_clr=%b compute_en=%b k=%0d", cyc, ifa.acc_clr, ifa.compute_en, ifa.k_idx);
      end
      if (ifa.compute_en && first_comp < 0) first_comp = cyc;
      if (ifa.acc_clr) clr_cnt++;
      if (tile == 0 && ifa.load_en) ld_first++;
      if (tile == 0 && ifa.out_valid) begin
        ov_first++;
        if (ifa.col_idx !== 1'b0) col_held = 0;
      end
      if (ifa.done) begin dcnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (ifa.out_valid && ifa.out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL handshake_extra: cyc=%0d unexpected tile (%0d,%0d)", cyc, ifa.row_idx, ifa.col_idx);
        end else begin
          e = sb.pop_front();
          if (ifa.row_idx !== e.r || ifa.col_idx !== e.c) begin
            n_bad++; $display("FAIL handshake_rc: cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc, ifa.row_idx, ifa.col_idx, e.r, e.c);
          end
        end
        tile++;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        n_cmp++;
        if (ifa.state_out !== 3'd0 || ifa.done !== 1'b0) begin
          n_bad++; $display("FAIL after_done_idle: state=%0d done=%b exp 0/0", ifa.state_out, ifa.done);
        end
        break;
      end
    end
    n_cmp++;
    if (done_cyc != exp_done) begin
      n_bad++; $display("FAIL done_cycle: got %0d exp %0d", done_cyc, exp_done);
    end
    n_cmp++;
    if (dcnt != 1 || sb.size() != 0) begin
      n_bad++; $display("FAIL done_once_sb_empty: done_cycles=%0d exp 1, tiles_left=%0d exp 0", dcnt, sb.size());
    end
  endtask

  task automatic test_sweep();
    int fc, ld, ov, cc; bit ch;
    run_a(0, 0, 21, fc, ld, ov, cc, ch);
    n_cmp++;
    if (fc != 2 || ld != 1 || ov != 1 || cc != 4) begin
      n_bad++; $display("FAIL sweep_phases: first_comp=%0d ld=%0d ov=%0d clr=%0d exp 2/1/1/4", fc, ld, ov, cc);
    end
  endtask

  task automatic test_load_stall();
    int fc, ld, ov, cc; bit ch;
    run_a(5, 0, 26, fc, ld, ov, cc, ch);
    n_cmp++;
    if (ld != 6 || fc != 7 || cc != 4) begin
      n_bad++; $display("FAIL load_stall: load_en=%0d first_comp=%0d clr=%0d exp 6/7/4", ld, fc, cc);
    end
  endtask

  task automatic test_write_stall();
    int fc, ld, ov, cc; bit ch;
    run_a(0, 3, 24, fc, ld, ov, cc, ch);
    n_cmp++;
    if (ov != 4 || ch != 1'b1) begin
      n_bad++; $display("FAIL write_stall: out_valid=%0d col_held=%b exp 4/1", ov, ch);
    end
  endtask

  task automatic test_abort();
    bit found = 0;
    bit saw_done = 0;
    ifa.load_valid = 1; ifa.out_ready = 1;
    @(negedge clk); ifa.start = 1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ifa.start = 0;
      if (ifa.state_out == 3'd2 && ifa.k_idx == 2'd1) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL abort_reach: COMPUTE k=1 not reached, state=%0d", ifa.state_out);
    end
    ifa.abort = 1;
    @(negedge clk); ifa.abort = 0;
    n_cmp++;
    if (ifa.state_out !== 3'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 ||
        ifa.row_idx !== 1'b0 || ifa.col_idx !== 1'b0 || ifa.k_idx !== 2'd0) begin
      n_bad++; $display("FAIL abort_idle: state=%0d busy=%b done=%b k=%0d exp all 0", ifa.state_out, ifa.busy, ifa.done, ifa.k_idx);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++; $display("FAIL abort_no_done: done/busy seen after abort, exp none");
    end
  endtask

  task automatic test_async_reset();
    int fc, ld, ov, cc; bit ch;
    bit found = 0;
    ifa.load_valid = 1; ifa.out_ready = 0;
    @(negedge clk); ifa.start = 1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ifa.start = 0;
      if (ifa.state_out == 3'd3) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL async_reach: WRITE not reached, state=%0d", ifa.state_out);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ifa.load_en, ifa.compute_en, ifa.acc_clr, ifa.out_valid, ifa.done, ifa.busy,
         ifa.row_idx, ifa.col_idx, ifa.k_idx, ifa.state_out} !== '0) begin
      n_bad++; $display("FAIL async_reset: state=%0d out_valid=%b busy=%b exp all 0", ifa.state_out, ifa.out_valid, ifa.busy);
    end
    @(negedge clk); rst = 1'b0; ifa.out_ready = 1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (ifa.state_out !== 3'd0) begin
      n_bad++; $display("FAIL post_reset_idle: state=%0d exp 0", ifa.state_out);
    end
    run_a(0, 0, 21, fc, ld, ov, cc, ch);
  endtask

  task automatic test_k1();
    logic [2:0] exp_st [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    ifb.load_valid = 1; ifb.out_ready = 1;
    @(negedge clk); ifb.start = 1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 5) ifb.start = 0;
      n_cmp++;
      if (ifb.state_out !== exp_st[cyc-1] || ifb.done !== (cyc == 4) ||
          ifb.compute_en !== (cyc == 2) || ifb.acc_clr !== (cyc == 2)) begin
        n_bad++; $display("FAIL k1_cyc%0d: state=%0d done=%b comp=%b clr=%b exp state=%0d", cyc, ifb.state_out, ifb.done, ifb.compute_en, ifb.acc_clr, exp_st[cyc-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_load_stall();
    test_write_stall();
    test_abort();
    test_async_reset();
    test_k1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
